mmio_bus_fabric: RTL and testbench

//  Parametrised successor of the CPU-side memory/MMIO wrapper. Decodes a CPU data-bus request

---
 rtl/mmio_bus_fabric_if.sv | 34 +++
 rtl/mmio_bus_fabric.sv | 182 ++++++++++++++++++
 tb/tb_mmio_bus_fabric.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_bus_fabric_if.sv
// CPU data-bus and peripheral-channel bundle for mmio_bus_fabric.
// The fabric takes the slave view; the CPU/peripheral side takes the master view.
interface mmio_bus_fabric_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NCH        = 4
);
    logic                      req;
    logic                      we;
    logic                      mmio;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     din;
    logic [DATA_WIDTH-1:0]     dout;
    logic                      ready;
    logic                      err;
    logic                      busy;
    logic [ADDR_WIDTH-1:0]     err_addr;
    logic [NCH-1:0]            ch_req;
    logic                      ch_we;
    logic [ADDR_WIDTH-1:0]     ch_addr;
    logic [DATA_WIDTH-1:0]     ch_wdata;
    logic [NCH*DATA_WIDTH-1:0] ch_rdata;
    logic [NCH-1:0]            ch_ack;

    modport master (
        output req, we, mmio, addr, din, ch_rdata, ch_ack,
        input  dout, ready, err, busy, err_addr, ch_req, ch_we, ch_addr, ch_wdata
    );

    modport slave (
        input  req, we, mmio, addr, din, ch_rdata, ch_ack,
        output dout, ready, err, busy, err_addr, ch_req, ch_we, ch_addr, ch_wdata
    );
endinterface

// File: rtl/mmio_bus_fabric.sv
// CPU-side fabric: decodes a bus request into internal sync RAM or one of NCH
// req/ack peripheral channels, with a wait-state timeout and a sticky fault address.
module mmio_bus_fabric #(
    parameter int                          DATA_WIDTH = 8,
    parameter int                          ADDR_WIDTH = 8,
    parameter int                          NCH        = 4,
    parameter logic [NCH*ADDR_WIDTH-1:0]   CH_BASE    = {8'h11, 8'h10, 8'h00, 8'h00},
    parameter logic [NCH*ADDR_WIDTH-1:0]   CH_MASK    = {8'hFF, 8'hFF, 8'hF0, 8'h00},
    parameter int                          TIMEOUT    = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    mmio_bus_fabric_if.slave       bus
);
    typedef enum logic [1:0] {S_IDLE, S_RAM, S_WAIT, S_RESP} state_e;

    localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
    logic [NCH-1:0]          ch_req_q, ch_req_d;
    logic                    ch_we_q, ch_we_d;
    logic [ADDR_WIDTH-1:0]   ch_addr_q, ch_addr_d;
    logic [DATA_WIDTH-1:0]   ch_wdata_q, ch_wdata_d;
    logic                    ram_we_q, ram_we_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_rd_q;

    logic [NCH-1:0]          hit_s, sel_s;
    logic                    ack_s;
    logic [DATA_WIDTH-1:0]   rdata_s;
    logic [DATA_WIDTH-1:0]   ram_view_s;
    logic                    ram_acc_s;

    assign ram_acc_s  = (state_q == S_IDLE) & bus.req & ~bus.mmio;
    assign ram_view_s = ram_we_q ? '0 : ram_rd_q;

    // Window decode, lowest-index priority select and selected-channel return path.
    always_comb begin
        hit_s = '0;
        for (int k = 0; k < NCH; k++) begin
            hit_s[k] = bus.mmio &
                ((bus.addr & CH_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) == CH_BASE[k*ADDR_WIDTH +: ADDR_WIDTH]);
        end
        // two's-complement trick isolates the lowest set hit bit
        sel_s   = hit_s & (~hit_s + NCH'(1'b1));
        ack_s   = |(bus.ch_ack & ch_req_q);
        rdata_s = '0;
        for (int k = 0; k < NCH; k++) begin
            rdata_s = rdata_s | (bus.ch_rdata[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{ch_req_q[k]}});
        end
    end

    // Next-state and next-output logic for the access FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        ready_d    = 1'b0;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        ch_req_d   = ch_req_q;
        ch_we_d    = ch_we_q;
        ch_addr_d  = ch_addr_q;
        ch_wdata_d = ch_wdata_q;
        ram_we_d   = ram_we_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (ram_acc_s) begin
                    state_d  = S_RAM;
                    ready_d  = 1'b1;
                    err_d    = 1'b0;
                    ram_we_d = bus.we;
                end else if (bus.req && (|hit_s)) begin
                    state_d    = S_WAIT;
                    ch_req_d   = sel_s;
                    ch_we_d    = bus.we;
                    ch_addr_d  = bus.addr;
                    ch_wdata_d = bus.din;
                end else if (bus.req) begin
                    state_d    = S_RESP;
                    ready_d    = 1'b1;
                    err_d      = 1'b1;
                    err_addr_d = bus.addr;
                    dout_d     = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RAM: begin
                dout_d  = ram_view_s;
                state_d = S_IDLE;
            end
            S_WAIT: begin
                if (ack_s) begin
                    dout_d   = ch_we_q ? '0 : rdata_s;
                    err_d    = 1'b0;
                    ch_req_d = '0;
                    ready_d  = 1'b1;
                    state_d  = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    dout_d     = '0;
                    err_d      = 1'b1;
                    err_addr_d = ch_addr_q;
                    ch_req_d   = '0;
                    ready_d    = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1'b1);
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dout_q     <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_addr_q <= '0;
            ch_req_q   <= '0;
            ch_we_q    <= 1'b0;
            ch_addr_q  <= '0;
            ch_wdata_q <= '0;
            ram_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            err_addr_q <= err_addr_d;
            ch_req_q   <= ch_req_d;
            ch_we_q    <= ch_we_d;
            ch_addr_q  <= ch_addr_d;
            ch_wdata_q <= ch_wdata_d;
            ram_we_q   <= ram_we_d;
        end
    end

    // Internal RAM: contents survive reset, read is synchronous.
    always_ff @(posedge clk_i) begin
        if (ram_acc_s && bus.we) begin
            mem[bus.addr] <= bus.din;
        end
        if (ram_acc_s && !bus.we) begin
            ram_rd_q <= mem[bus.addr];
        end
    end

    // The RAM word is only presented during its completion cycle, then held in dout_q.
    assign bus.dout     = (state_q == S_RAM) ? ram_view_s : dout_q;
    assign bus.ready    = ready_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
    assign bus.err_addr = err_addr_q;
    assign bus.ch_req   = ch_req_q;
    assign bus.ch_we    = ch_we_q;
    assign bus.ch_addr  = ch_addr_q;
    assign bus.ch_wdata = ch_wdata_q;
endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Scoreboard bench for mmio_bus_fabric: a driver pushes expected responses computed
// from a behavioural model; a monitor pops and compares on every ready pulse.
module tb_mmio_bus_fabric;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic [7:0] dout;
        logic       err;
        logic [7:0] err_addr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    // channel 0 covers 00-07 and overlaps channel 1 (00-0F); 10 and 11 are single-address windows
    logic [7:0] base_m [4] = '{8'h00, 8'h00, 8'h10, 8'h11};
    logic [7:0] mask_m [4] = '{8'hF8, 8'hF0, 8'hFF, 8'hFF};
    logic [7:0] ram_m  [256];
    bit         written[256];
    logic [7:0] err_addr_m;

    mmio_bus_fabric_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NCH(4)) bus ();

    mmio_bus_fabric #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8),
        .NCH(4),
        .CH_BASE({8'h11, 8'h10, 8'h00, 8'h00}),
        .CH_MASK({8'hFF, 8'hFF, 8'hF0, 8'hF8}),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_sel(input logic [7:0] a);
        for (int k = 0; k < 4; k++) begin
            if ((a & mask_m[k]) == base_m[k]) return k;
        end
        return -1;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_ready: got ready=1 expected no response at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", 32'(bus.dout), 32'(e.dout));
                    check("err", 32'(bus.err), 32'(e.err));
                    check("err_addr", 32'(bus.err_addr), 32'(e.err_addr));
                end
            end
        end
    end

    task automatic do_txn(input logic w, input logic m, input logic [7:0] a, input logic [7:0] d_in,
                          input int dly, input logic [7:0] rv, input logic [3:0] stray);
        exp_t       e;
        int         ch;
        int         wcyc;
        int         lat;
        bit         done;
        logic [3:0] sel;
        ch   = m ? model_sel(a) : -1;
        sel  = (ch >= 0) ? (4'b0001 << ch) : 4'b0000;
        wcyc = (ch < 0) ? 0 : ((dly <= TIMEOUT) ? dly : TIMEOUT);
        if (!m) begin
            e.err = 1'b0;
            if (w) begin
                ram_m[a]   = d_in;
                written[a] = 1'b1;
                e.dout     = 8'h00;
            end else begin
                e.dout = ram_m[a];
            end
        end else if (ch < 0 || dly > TIMEOUT) begin
            e.err      = 1'b1;
            e.dout     = 8'h00;
            err_addr_m = a;
        end else begin
            e.err  = 1'b0;
            e.dout = w ? 8'h00 : rv;
        end
        e.err_addr = err_addr_m;

        @(negedge clk);
        bus.req  = 1'b1;
        bus.we   = w;
        bus.mmio = m;
        bus.addr = a;
        bus.din  = d_in;
        exp_q.push_back(e);
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 64) begin
            @(negedge clk);
            lat++;
            if (lat <= wcyc) begin
                check("ch_req", 32'(bus.ch_req), 32'(sel));
                check("busy", 32'(bus.busy), 32'd1);
                check("ch_we", 32'(bus.ch_we), 32'(w));
                check("ch_addr", 32'(bus.ch_addr), 32'(a));
                check("ch_wdata", 32'(bus.ch_wdata), 32'(d_in));
                bus.ch_rdata = $urandom;
                if (lat == dly) begin
                    bus.ch_ack = sel;
                    for (int k = 0; k < 4; k++) begin
                        if (sel[k]) bus.ch_rdata[k*8 +: 8] = rv;
                    end
                    bus.req = 1'b0;
                end else begin
                    // stray acks and an ignored RAM write request while the channel waits
                    bus.ch_ack = stray & ~sel;
                    bus.req    = 1'b1;
                    bus.we     = 1'b1;
                    bus.mmio   = 1'b0;
                    bus.addr   = 8'($urandom);
                    bus.din    = 8'($urandom);
                end
            end else begin
                bus.req    = 1'b0;
                bus.ch_ack = 4'b0000;
                if (bus.ready) done = 1'b1;
            end
        end
        check("latency", 32'(lat), 32'(wcyc + 1));
        check("ch_req_released", 32'(bus.ch_req), 32'd0);
    endtask

    task automatic reset_in_wait();
        @(negedge clk);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.mmio = 1'b1;
        bus.addr = 8'h10;
        @(negedge clk);
        bus.req = 1'b0;
        check("rst_wait_ch_req", 32'(bus.ch_req), 32'h4);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ch_req", 32'(bus.ch_req), 32'd0);
        check("rst_async_busy", 32'(bus.busy), 32'd0);
        check("rst_async_ready", 32'(bus.ready), 32'd0);
        check("rst_async_err_addr", 32'(bus.err_addr), 32'd0);
        err_addr_m = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       w;
        logic       m;
        logic [7:0] a;
        int         dly;
        n_checks     = 0;
        n_errors     = 0;
        err_addr_m   = 8'h00;
        rst_n        = 1'b0;
        bus.req      = 1'b0;
        bus.we       = 1'b0;
        bus.mmio     = 1'b0;
        bus.addr     = 8'h00;
        bus.din      = 8'h00;
        bus.ch_rdata = 32'h0;
        bus.ch_ack   = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(bus.ready), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_dout", 32'(bus.dout), 32'd0);
        check("reset_err_addr", 32'(bus.err_addr), 32'd0);
        check("reset_ch_req", 32'(bus.ch_req), 32'd0);
        check("reset_ch_we", 32'(bus.ch_we), 32'd0);
        check("reset_ch_addr", 32'(bus.ch_addr), 32'd0);
        check("reset_ch_wdata", 32'(bus.ch_wdata), 32'd0);
        rst_n = 1'b1;

        do_txn(1'b1, 1'b0, 8'h3C, 8'hA5, 0, 8'h00, 4'b0000);
        do_txn(1'b0, 1'b0, 8'h3C, 8'h00, 0, 8'h00, 4'b0000);
        do_txn(1'b0, 1'b1, 8'h10, 8'h00, 3, 8'h5A, 4'b0000);
        do_txn(1'b0, 1'b1, 8'h80, 8'h00, 1, 8'h00, 4'b0000);
        do_txn(1'b1, 1'b1, 8'h11, 8'h3E, 99, 8'h00, 4'b0000);
        do_txn(1'b0, 1'b1, 8'h05, 8'h00, 2, 8'hC3, 4'b0100);
        do_txn(1'b0, 1'b1, 8'h11, 8'h00, TIMEOUT, 8'h96, 4'b0111);
        do_txn(1'b0, 1'b1, 8'h10, 8'h00, TIMEOUT + 1, 8'h77, 4'b1011);
        reset_in_wait();
        do_txn(1'b0, 1'b0, 8'h3C, 8'h00, 0, 8'h00, 4'b0000);

        for (int i = 0; i < 200; i++) begin
            w = 1'($urandom);
            m = 1'($urandom);
            if (!m) begin
                a = 8'($urandom);
                if (!written[a]) w = 1'b1;
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = 8'($urandom_range(0, 15));
                    1:       a = 8'h10;
                    2:       a = 8'h11;
                    default: a = 8'($urandom);
                endcase
            end
            dly = ($urandom_range(0, 3) == 0) ? $urandom_range(13, 18) : $urandom_range(1, 5);
            do_txn(w, m, a, 8'($urandom), dly, 8'($urandom), 4'($urandom));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
